spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_xfer_arbiter_if.sv | 33 +++
 rtl/spi_xfer_arbiter.sv | 85 ++++++++
 tb/tb_spi_xfer_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester and SPI-master signal bundle for the transfer arbiter.
interface spi_xfer_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_txdata;
  logic [16*NREQ-1:0]   req_cfg;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_rxdata;
  logic                 rsp_err;
  logic [5:0]           m_bpt;
  logic                 m_cpol;
  logic                 m_cpha;
  logic                 m_msb;
  logic [3:0]           m_numss;
  logic [2:0]           m_clks;
  logic                 m_en;
  logic [31:0]          m_txdatal;
  logic [31:0]          m_txdatah;
  logic                 m_busy;
  logic                 m_err;
  logic [31:0]          m_rxdatal;
  logic [31:0]          m_rxdatah;
  modport master (
    input  req_valid, req_txdata, req_cfg, m_busy, m_err, m_rxdatal, m_rxdatah,
    output req_ready, rsp_valid, rsp_rxdata, rsp_err, m_bpt, m_cpol, m_cpha, m_msb,
           m_numss, m_clks, m_en, m_txdatal, m_txdatah
  );
  modport slave (
    output req_valid, req_txdata, req_cfg, m_busy, m_err, m_rxdatal, m_rxdatah,
    input  req_ready, rsp_valid, rsp_rxdata, rsp_err, m_bpt, m_cpol, m_cpha, m_msb,
           m_numss, m_clks, m_en, m_txdatal, m_txdatah
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter serialising requester transfers onto one SPI master.
module spi_xfer_arbiter #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 65535
) (
  input logic PCLK,
  input logic PRESETn,
  spi_xfer_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  typedef enum logic [2:0] {IDLE, SETUP, START, XFER, RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, gi, g;
  logic [3:0] s;
  logic [15:0] cfg_q, cnt;
  logic [63:0] tx_q, rx_q;
  logic hit, grant, tmo, err_q;
  always_comb begin
    hit = 1'b0;
    gi = '0;
    s = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = 4'(rr_ptr) + 4'(i);
      s = (s >= 4'(NREQ)) ? s - 4'(NREQ) : s;
      if (!hit && bus.req_valid[s[IW-1:0]]) begin
        hit = 1'b1;
        gi = s[IW-1:0];
      end
    end
  end
  assign grant = state == IDLE && hit;
  // a phase times out only while the master has not yet made the awaited busy transition
  assign tmo = cnt == 16'(TO_CYCLES - 1) &&
               ((state == START && !bus.m_busy) || (state == XFER && bus.m_busy));
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hit ? SETUP : IDLE;
      SETUP:   nxt = START;
      START:   nxt = bus.m_busy ? XFER : tmo ? RESP : START;
      XFER:    nxt = (!bus.m_busy || tmo) ? RESP : XFER;
      default: nxt = IDLE;
    endcase
    bus.req_ready = (grant && PRESETn) ? ONE << gi : '0;
    bus.rsp_valid = (state == RESP) ? ONE << g : '0;
    bus.m_en = state == START || state == XFER;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr <= '0;
      g <= '0;
      cfg_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + 16'd1;
      if (grant) begin
        g <= gi;
        rr_ptr <= (gi == IW'(NREQ - 1)) ? '0 : gi + 1'b1;
        cfg_q <= bus.req_cfg[16*gi +: 16];
        tx_q <= bus.req_txdata[64*gi +: 64];
        rx_q <= '0;
        err_q <= 1'b0;
      end
      if ((state == START || state == XFER) && (bus.m_err || tmo)) err_q <= 1'b1;
      if (state == XFER && nxt == RESP) rx_q <= tmo ? '0 : {bus.m_rxdatah, bus.m_rxdatal};
    end
  end
  assign bus.m_bpt = cfg_q[5:0];
  assign bus.m_cpol = cfg_q[6];
  assign bus.m_cpha = cfg_q[7];
  assign bus.m_msb = cfg_q[8];
  assign bus.m_numss = cfg_q[12:9];
  assign bus.m_clks = cfg_q[15:13];
  assign bus.m_txdatal = tx_q[31:0];
  assign bus.m_txdatah = tx_q[63:32];
  assign bus.rsp_rxdata = rx_q;
  assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: random requesters and a behavioural SPI master, scoreboarded responses.
module tb_spi_xfer_arbiter;
  localparam int NREQ = 4;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;
  spi_xfer_arbiter_if #(.NREQ(NREQ)) bus();
  spi_xfer_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
  typedef struct {
    int d0;
    int d1;
    int e;
    logic [63:0] rx;
    logic [63:0] tx;
    logic [15:0] cfg;
  } scen_t;
  typedef struct {
    int g;
    logic [63:0] rx;
    logic err;
  } exp_t;
  scen_t scq[$];
  exp_t sbq[$];
  int total = 0, bad = 0, gnt_cnt = 0, last_gnt = 0, seen = 0, ptr = 0, gp, last_k, k, start_cnt;
  logic directed = 1'b1, long_mode = 1'b0, tos, tox;
  logic [NREQ-1:0] dir_valid = '0;
  scen_t sc, sm;
  exp_t ex, er;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // requester driver
  initial begin
    bus.req_valid = '0;
    bus.req_txdata = '0;
    bus.req_cfg = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (directed) bus.req_valid = dir_valid;
      else
        for (int i = 0; i < NREQ; i++) begin
          if (seen != gnt_cnt && last_gnt == i) begin
            bus.req_valid[i] = 1'b0;
            bus.req_txdata[64*i +: 64] = {$urandom, $urandom};
          end else if (bus.req_valid[i]) begin
            if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            bus.req_valid[i] = 1'b1;
            bus.req_txdata[64*i +: 64] = {$urandom, $urandom};
            bus.req_cfg[16*i +: 16] = 16'($urandom);
          end
        end
      seen = gnt_cnt;
    end
  end
  // grant checker: reference round robin plus expected outcome of the drawn master behaviour
  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        ptr = 0;
        sbq.delete();
        scq.delete();
      end else if (bus.req_ready != '0) begin
        gp = -1;
        for (int i = 0; i < NREQ; i++)
          if (gp < 0 && bus.req_valid[(ptr + i) % NREQ]) gp = (ptr + i) % NREQ;
        chk("grant", 64'(bus.req_ready), (gp < 0) ? 64'd0 : 64'd1 << gp);
        if (gp >= 0) begin
          ptr = (gp + 1) % NREQ;
          case ($urandom_range(0, 5))
            0: sc.d0 = 0;
            1: sc.d0 = 1;
            2: sc.d0 = TO - 1;
            3: sc.d0 = TO;
            default: sc.d0 = $urandom_range(0, TO + 2);
          endcase
          case ($urandom_range(0, 4))
            0: sc.d1 = 1;
            1: sc.d1 = TO;
            2: sc.d1 = TO + 1;
            default: sc.d1 = $urandom_range(1, TO + 3);
          endcase
          sc.e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sc.d0 + sc.d1 + 2) : -1;
          if (long_mode) begin
            sc.d0 = 0;
            sc.d1 = 12;
            sc.e = -1;
          end
          sc.rx = {$urandom, $urandom};
          sc.tx = bus.req_txdata[64*gp +: 64];
          sc.cfg = bus.req_cfg[16*gp +: 16];
          scq.push_back(sc);
          tos = sc.d0 >= TO;
          tox = !tos && sc.d1 > TO;
          last_k = tos ? TO - 1 : tox ? sc.d0 + TO : sc.d0 + sc.d1;
          ex.g = gp;
          ex.rx = (tos || tox) ? 64'd0 : sc.rx;
          ex.err = tos || tox || (sc.e >= 0 && sc.e <= last_k);
          sbq.push_back(ex);
          last_gnt = gp;
          gnt_cnt++;
        end
      end
    end
  end
  // behavioural SPI master: busy rises d0 cycles after enable and lasts d1 cycles
  initial begin
    bus.m_busy = 1'b0;
    bus.m_err = 1'b0;
    bus.m_rxdatal = '0;
    bus.m_rxdatah = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (bus.m_en && PRESETn) begin
        if (scq.size() == 0) begin
          chk("scenario_available", 64'd0, 64'd1);
          sm = '{d0: 0, d1: 1, e: -1, rx: 64'd0, tx: 64'd0, cfg: 16'd0};
        end else sm = scq.pop_front();
        bus.m_rxdatal = sm.rx[31:0];
        bus.m_rxdatah = sm.rx[63:32];
        chk("m_cfg", 64'({bus.m_clks, bus.m_numss, bus.m_msb, bus.m_cpha, bus.m_cpol, bus.m_bpt}), 64'(sm.cfg));
        chk("m_tx", {bus.m_txdatah, bus.m_txdatal}, sm.tx);
        k = 0;
        while (bus.m_en) begin
          bus.m_busy = k >= sm.d0 && k < sm.d0 + sm.d1;
          bus.m_err = k == sm.e;
          @(posedge PCLK);
          #1;
          k++;
        end
        bus.m_busy = 1'b0;
        bus.m_err = 1'b0;
      end
    end
  end
  // response monitor
  initial begin
    forever begin
      @(negedge PCLK);
      if (bus.rsp_valid != '0) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        else begin
          er = sbq.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'd1 << er.g);
          chk("rsp_rxdata", bus.rsp_rxdata, er.rx);
          chk("rsp_err", 64'(bus.rsp_err), 64'(er.err));
          chk("m_en_in_resp", 64'(bus.m_en), 64'd0);
        end
      end
    end
  end
  task automatic drain();
    repeat (2) @(negedge PCLK);
    for (int c = 0; c < 500 && (sbq.size() != 0 || bus.m_en); c++) @(negedge PCLK);
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge PCLK);
  endtask
  initial begin
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rxdata", bus.rsp_rxdata, 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_m_en", 64'(bus.m_en), 64'd0);
    chk("rst_m_tx", {bus.m_txdatah, bus.m_txdatal}, 64'd0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    directed = 1'b0;
    for (int c = 0; c < 20000 && gnt_cnt < 40; c++) @(posedge PCLK);
    chk("random_progress", 64'(gnt_cnt >= 40), 64'd1);
    directed = 1'b1;
    dir_valid = '0;
    drain();
    long_mode = 1'b1;
    dir_valid = 4'b0100;
    for (int c = 0; c < 200 && !(bus.m_en && bus.m_busy); c++) @(negedge PCLK);
    chk("reached_xfer", 64'(bus.m_en && bus.m_busy), 64'd1);
    dir_valid = '0;
    long_mode = 1'b0;
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_m_en", 64'(bus.m_en), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_m_tx", {bus.m_txdatah, bus.m_txdatal}, 64'd0);
    chk("mid_rst_rxdata", bus.rsp_rxdata, 64'd0);
    dir_valid = '1;
    start_cnt = gnt_cnt;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("grant_after_reset", 64'(bus.req_ready), 64'd1);
    for (int c = 0; c < 2000 && gnt_cnt < start_cnt + 5; c++) @(posedge PCLK);
    chk("rr_progress", 64'(gnt_cnt >= start_cnt + 5), 64'd1);
    dir_valid = '0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
